// File: rtl/pc_unit.sv
// Program counter stage: holds the fetch address, applies the decoder's
// set/output/lock control code, and keeps a small LIFO of return addresses
// for interrupt entry and recovery.
module pc_unit #(
    parameter logic [15:0] RESET_ADDR  = 16'h0000,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned PTR_W       = 3
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [2:0]       i_pc_control_code,
    input  logic [15:0]      i_set_addr,
    input  logic             i_interrupt,
    input  logic [15:0]      i_int_vector,
    input  logic             i_recover,
    input  logic             i_err_clr,
    output logic [15:0]      o_addr_bus,
    output logic             o_addr_en,
    output logic [15:0]      o_pc,
    output logic [PTR_W-1:0] o_depth,
    output logic             o_stack_full,
    output logic             o_stack_empty,
    output logic             o_int_overflow,
    output logic             o_rec_underflow
);

    localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
    localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(STACK_DEPTH);

    logic [15:0]      pc_q, pc_d;
    logic [PTR_W-1:0] depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             push;
    logic [15:0]      stack_q [STACK_DEPTH];

    logic             ctl_set, ctl_out, ctl_lock;
    logic             full, empty;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [PTR_W-1:0] rd_ptr;

    assign ctl_set  = i_pc_control_code[0];
    assign ctl_out  = i_pc_control_code[1];
    assign ctl_lock = i_pc_control_code[2];

    assign full   = (depth_q == FULL_CNT);
    assign empty  = (depth_q == '0);
    assign rd_ptr = depth_q - PTR_W'(1);
    assign wr_idx = depth_q[IDX_W-1:0];
    assign rd_idx = rd_ptr[IDX_W-1:0];

    // Next-state selection: interrupt > recover > lock > set > fetch > hold.
    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        push    = 1'b0;
        // Clear applies first so that a same-cycle set event overrides it.
        ovf_d   = ovf_q & ~i_err_clr;
        udf_d   = udf_q & ~i_err_clr;
        if (i_interrupt) begin
            if (!full) begin
                push    = 1'b1;
                depth_d = depth_q + PTR_W'(1);
                pc_d    = i_int_vector;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (i_recover) begin
            if (!empty) begin
                pc_d    = stack_q[rd_idx];
                depth_d = rd_ptr;
            end else begin
                udf_d = 1'b1;
            end
        end else if (ctl_lock) begin
            pc_d = pc_q;
        end else if (ctl_set) begin
            // Set takes precedence over fetch: JMP (3'b011) does not increment.
            pc_d = i_set_addr;
        end else if (ctl_out) begin
            pc_d = pc_q + 16'd1;
        end
    end

    // PC, stack pointer and sticky flags with asynchronous reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pc_q    <= RESET_ADDR;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Return-address storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push && n_rst) begin
            stack_q[wr_idx] <= pc_q;
        end
    end

    assign o_addr_en       = ctl_out & ~ctl_lock;
    assign o_addr_bus      = o_addr_en ? pc_q : 16'h0000;
    assign o_pc            = pc_q;
    assign o_depth         = depth_q;
    assign o_stack_full    = full;
    assign o_stack_empty   = empty;
    assign o_int_overflow  = ovf_q;
    assign o_rec_underflow = udf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed-vector bench for pc_unit: a table of per-cycle stimulus with
// hand-computed expectations, plus an asynchronous-reset sequence.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [2:0]  code;
    logic [15:0] set_addr;
    logic        intr;
    logic [15:0] vec;
    logic        rec;
    logic        clr;
    logic [15:0] addr_bus;
    logic        addr_en;
    logic [15:0] pc;
    logic [2:0]  depth;
    logic        full, empty, ovf, udf;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_unit #(
        .RESET_ADDR (16'h0000),
        .STACK_DEPTH(4),
        .PTR_W      (3)
    ) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .i_pc_control_code(code),
        .i_set_addr       (set_addr),
        .i_interrupt      (intr),
        .i_int_vector     (vec),
        .i_recover        (rec),
        .i_err_clr        (clr),
        .o_addr_bus       (addr_bus),
        .o_addr_en        (addr_en),
        .o_pc             (pc),
        .o_depth          (depth),
        .o_stack_full     (full),
        .o_stack_empty    (empty),
        .o_int_overflow   (ovf),
        .o_rec_underflow  (udf)
    );

    typedef struct {
        logic [2:0]  code;
        logic [15:0] set_addr;
        logic        intr;
        logic [15:0] vec;
        logic        rec;
        logic        clr;
        logic [15:0] e_bus;   // before the edge
        logic        e_en;    // before the edge
        logic [15:0] e_pc;    // after the edge
        logic [2:0]  e_depth;
        logic        e_ovf;
        logic        e_udf;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    function automatic vec_t mk(logic [2:0] c, logic [15:0] sa, logic it, logic [15:0] v,
                                logic r, logic cl, logic [15:0] eb, logic ee,
                                logic [15:0] ep, logic [2:0] ed, logic eo, logic eu);
        vec_t t;
        t.code = c; t.set_addr = sa; t.intr = it; t.vec = v; t.rec = r; t.clr = cl;
        t.e_bus = eb; t.e_en = ee; t.e_pc = ep; t.e_depth = ed; t.e_ovf = eo; t.e_udf = eu;
        return t;
    endfunction

    task automatic chk(input string name, input int step, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", name, step, act, exp);
        end
    endtask

    task automatic chk_state(input int step, input logic [15:0] e_pc, input logic [2:0] e_depth,
                             input logic e_ovf, input logic e_udf);
        chk("pc", step, pc, e_pc);
        chk("depth", step, 16'(depth), 16'(e_depth));
        chk("full", step, 16'(full), 16'(e_depth == 3'd4));
        chk("empty", step, 16'(empty), 16'(e_depth == 3'd0));
        chk("int_overflow", step, 16'(ovf), 16'(e_ovf));
        chk("rec_underflow", step, 16'(udf), 16'(e_udf));
    endtask

    task automatic drive_idle();
        code = 3'b000; set_addr = 16'h0; intr = 1'b0; vec = 16'h0; rec = 1'b0; clr = 1'b0;
    endtask

    initial begin
        //            code    set      int  vec      rec  clr  bus      en   pc       d  ov un
        tbl[0]  = mk(3'b010, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0001, 0, 0, 0);
        tbl[1]  = mk(3'b010, 16'h0000, 0, 16'h0000, 0, 0, 16'h0001, 1, 16'h0002, 0, 0, 0);
        tbl[2]  = mk(3'b010, 16'h0000, 0, 16'h0000, 0, 0, 16'h0002, 1, 16'h0003, 0, 0, 0);
        tbl[3]  = mk(3'b011, 16'h0005, 0, 16'h0000, 0, 0, 16'h0003, 1, 16'h0005, 0, 0, 0);
        tbl[4]  = mk(3'b011, 16'h1234, 0, 16'h0000, 0, 0, 16'h0005, 1, 16'h1234, 0, 0, 0);
        tbl[5]  = mk(3'b100, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h1234, 0, 0, 0);
        tbl[6]  = mk(3'b111, 16'h5555, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h1234, 0, 0, 0);
        tbl[7]  = mk(3'b001, 16'hFFFF, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'hFFFF, 0, 0, 0);
        tbl[8]  = mk(3'b010, 16'h0000, 0, 16'h0000, 0, 0, 16'hFFFF, 1, 16'h0000, 0, 0, 0);
        tbl[9]  = mk(3'b001, 16'h0040, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0040, 0, 0, 0);
        tbl[10] = mk(3'b010, 16'h0000, 1, 16'h0100, 0, 0, 16'h0040, 1, 16'h0100, 1, 0, 0);
        tbl[11] = mk(3'b001, 16'h0102, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0102, 1, 0, 0);
        tbl[12] = mk(3'b000, 16'h0000, 1, 16'h0200, 0, 0, 16'h0000, 0, 16'h0200, 2, 0, 0);
        tbl[13] = mk(3'b011, 16'h9999, 0, 16'h0000, 1, 0, 16'h0200, 1, 16'h0102, 1, 0, 0);
        tbl[14] = mk(3'b000, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0040, 0, 0, 0);
        tbl[15] = mk(3'b000, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0040, 0, 0, 1);
        tbl[16] = mk(3'b000, 16'h0000, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0040, 0, 0, 0);
        tbl[17] = mk(3'b001, 16'h0010, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0010, 0, 0, 0);
        tbl[18] = mk(3'b000, 16'h0000, 1, 16'h0080, 1, 0, 16'h0000, 0, 16'h0080, 1, 0, 0);
        tbl[19] = mk(3'b000, 16'h0000, 1, 16'h0A01, 0, 0, 16'h0000, 0, 16'h0A01, 2, 0, 0);
        tbl[20] = mk(3'b000, 16'h0000, 1, 16'h0A02, 0, 0, 16'h0000, 0, 16'h0A02, 3, 0, 0);
        tbl[21] = mk(3'b000, 16'h0000, 1, 16'h0A03, 0, 0, 16'h0000, 0, 16'h0A03, 4, 0, 0);
        tbl[22] = mk(3'b011, 16'h7777, 1, 16'h0300, 0, 0, 16'h0A03, 1, 16'h0A03, 4, 1, 0);
        tbl[23] = mk(3'b000, 16'h0000, 1, 16'h0400, 0, 1, 16'h0000, 0, 16'h0A03, 4, 1, 0);
        tbl[24] = mk(3'b000, 16'h0000, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0A03, 4, 0, 0);
        tbl[25] = mk(3'b000, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0A02, 3, 0, 0);
        tbl[26] = mk(3'b010, 16'h0000, 0, 16'h0000, 1, 0, 16'h0A02, 1, 16'h0A01, 2, 0, 0);

        drive_idle();
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_state(-1, 16'h0000, 3'd0, 1'b0, 1'b0);
        chk("addr_bus", -1, addr_bus, 16'h0000);
        n_rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            code = tbl[i].code; set_addr = tbl[i].set_addr; intr = tbl[i].intr;
            vec = tbl[i].vec; rec = tbl[i].rec; clr = tbl[i].clr;
            #1;
            chk("addr_bus", i, addr_bus, tbl[i].e_bus);
            chk("addr_en", i, 16'(addr_en), 16'(tbl[i].e_en));
            @(negedge clk);
            chk_state(i, tbl[i].e_pc, tbl[i].e_depth, tbl[i].e_ovf, tbl[i].e_udf);
        end

        // Asynchronous reset between edges with two return slots occupied.
        drive_idle();
        code = 3'b010;
        #2;
        n_rst = 1'b0;
        #1;
        chk_state(100, 16'h0000, 3'd0, 1'b0, 1'b0);
        chk("addr_bus", 100, addr_bus, 16'h0000);
        @(negedge clk);
        chk_state(101, 16'h0000, 3'd0, 1'b0, 1'b0);
        n_rst = 1'b1;
        #1;
        chk("addr_en", 102, 16'(addr_en), 16'h0001);
        @(negedge clk);
        chk_state(102, 16'h0001, 3'd0, 1'b0, 1'b0);

        // Recover after reset finds the stack empty.
        code = 3'b000; rec = 1'b1;
        @(negedge clk);
        chk_state(103, 16'h0001, 3'd0, 1'b0, 1'b1);
        drive_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
